// File: rtl/reg_file_fwd.sv
// reg_file_fwd: ID-stage register file with EX/MEM/WB bypass and load-use stall.
// Register 0 reads as zero and is never written. Reads are combinational.
// Optional macro REG_FILE_DEBUG_PORT_EN adds a registered, non-forwarding
// debug read port (dbg_addr -> dbg_data, 1-cycle latency).
module reg_file_fwd #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_read_en_1,
  input  logic [ADDR_WIDTH-1:0] reg_addr_1,
  input  logic                  reg_read_en_2,
  input  logic [ADDR_WIDTH-1:0] reg_addr_2,
  input  logic                  ex_write_en,
  input  logic [ADDR_WIDTH-1:0] ex_write_addr,
  input  logic [DATA_WIDTH-1:0] ex_write_data,
  input  logic                  ex_is_load,
  input  logic                  mem_write_en,
  input  logic [ADDR_WIDTH-1:0] mem_write_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  wb_write_en,
  input  logic [ADDR_WIDTH-1:0] wb_write_addr,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  stall_req
`ifdef REG_FILE_DEBUG_PORT_EN
  ,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
`endif
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [DATA_WIDTH-1:0] arr_1, arr_2;
  logic [DATA_WIDTH-1:0] fwd_1, fwd_2;
  logic                  load_hit_1, load_hit_2;

  // Resolve one read port: EX > MEM > WB > array. A matching EX load blocks
  // lower-priority bypass; the returned value is a don't-care while stalled.
  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic                  en,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] arr
  );
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    if (en && (addr != '0)) begin
      if (ex_write_en && (ex_write_addr == addr))
        d = ex_is_load ? arr : ex_write_data;
      else if (mem_write_en && (mem_write_addr == addr))
        d = mem_write_data;
      else if (wb_write_en && (wb_write_addr == addr))
        d = wb_write_data;
      else
        d = arr;
    end
    return d;
  endfunction

  // Register array; WB commits, $0 is never written, reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_write_en && (wb_write_addr != '0)) begin
      regs[wb_write_addr] <= wb_write_data;
    end
  end

  // Array look-up and bypass selection for both ports.
  always_comb begin
    arr_1 = regs[reg_addr_1];
    arr_2 = regs[reg_addr_2];
    fwd_1 = resolve(reg_read_en_1, reg_addr_1, arr_1);
    fwd_2 = resolve(reg_read_en_2, reg_addr_2, arr_2);
  end

  // Load-use detection against the EX destination (never $0).
  always_comb begin
    load_hit_1 = reg_read_en_1 && (reg_addr_1 == ex_write_addr);
    load_hit_2 = reg_read_en_2 && (reg_addr_2 == ex_write_addr);
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    read_data_1 = '0;
    read_data_2 = '0;
    stall_req   = 1'b0;
    if (rst_n) begin
      read_data_1 = fwd_1;
      read_data_2 = fwd_2;
      stall_req   = ex_write_en && ex_is_load && (ex_write_addr != '0) &&
                    (load_hit_1 || load_hit_2);
    end
  end

`ifdef REG_FILE_DEBUG_PORT_EN
  // Debug read of raw array content, one cycle latency, no forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                dbg_data <= '0;
    else if (dbg_addr == '0)   dbg_data <= '0;
    else                       dbg_data <= regs[dbg_addr];
  end
`endif

endmodule

// File: tb/tb_reg_file_fwd.sv
// Bench for reg_file_fwd: directed vectors with literal checks plus a
// per-cycle comparison against an architectural register-file model.
module tb_reg_file_fwd;

  logic        clk, rst_n;
  logic        reg_read_en_1, reg_read_en_2;
  logic [4:0]  reg_addr_1, reg_addr_2;
  logic        ex_write_en, ex_is_load;
  logic [4:0]  ex_write_addr;
  logic [31:0] ex_write_data;
  logic        mem_write_en;
  logic [4:0]  mem_write_addr;
  logic [31:0] mem_write_data;
  logic        wb_write_en;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic [31:0] read_data_1, read_data_2;
  logic        stall_req;
`ifdef REG_FILE_DEBUG_PORT_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] model_dbg;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] model_mem [32];

  reg_file_fwd #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_read_en_1(reg_read_en_1), .reg_addr_1(reg_addr_1),
    .reg_read_en_2(reg_read_en_2), .reg_addr_2(reg_addr_2),
    .ex_write_en(ex_write_en), .ex_write_addr(ex_write_addr),
    .ex_write_data(ex_write_data), .ex_is_load(ex_is_load),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .wb_write_en(wb_write_en), .wb_write_addr(wb_write_addr),
    .wb_write_data(wb_write_data),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .stall_req(stall_req)
`ifdef REG_FILE_DEBUG_PORT_EN
    , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural model: what a read of register r must return this cycle.
  function automatic logic [31:0] model_read(input logic en, input logic [4:0] r, output logic dc);
    dc = 1'b0;
    if (!rst_n || !en || r == 5'd0) return 32'd0;
    if (ex_write_en && ex_write_addr == r) begin
      if (ex_is_load) begin dc = 1'b1; return 32'd0; end
      return ex_write_data;
    end
    if (mem_write_en && mem_write_addr == r) return mem_write_data;
    if (wb_write_en && wb_write_addr == r) return wb_write_data;
    return model_mem[r];
  endfunction

  function automatic logic model_stall();
    if (!rst_n || !ex_write_en || !ex_is_load || ex_write_addr == 5'd0) return 1'b0;
    return (reg_read_en_1 && reg_addr_1 == ex_write_addr) ||
           (reg_read_en_2 && reg_addr_2 == ex_write_addr);
  endfunction

  initial for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;

  // Model state update: commits from WB, asynchronous clear on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model_mem[i] = 32'd0;
`ifdef REG_FILE_DEBUG_PORT_EN
      model_dbg = 32'd0;
`endif
    end else begin
`ifdef REG_FILE_DEBUG_PORT_EN
      model_dbg = (dbg_addr == 5'd0) ? 32'd0 : model_mem[dbg_addr];
`endif
      if (wb_write_en && wb_write_addr != 5'd0) model_mem[wb_write_addr] = wb_write_data;
    end
  end

  // Per-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] e1, e2;
    logic dc1, dc2;
    e1 = model_read(reg_read_en_1, reg_addr_1, dc1);
    e2 = model_read(reg_read_en_2, reg_addr_2, dc2);
    if (!dc1) check("cyc_rd1", read_data_1, e1);
    if (!dc2) check("cyc_rd2", read_data_2, e2);
    check("cyc_stall", {31'd0, stall_req}, {31'd0, model_stall()});
`ifdef REG_FILE_DEBUG_PORT_EN
    check("cyc_dbg", dbg_data, model_dbg);
`endif
  end

  task automatic idle();
    reg_read_en_1 = 0; reg_addr_1 = 0; reg_read_en_2 = 0; reg_addr_2 = 0;
    ex_write_en = 0; ex_write_addr = 0; ex_write_data = 0; ex_is_load = 0;
    mem_write_en = 0; mem_write_addr = 0; mem_write_data = 0;
    wb_write_en = 0; wb_write_addr = 0; wb_write_data = 0;
`ifdef REG_FILE_DEBUG_PORT_EN
    dbg_addr = 0;
`endif
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    reg_read_en_1 = 1; reg_addr_1 = a1; reg_read_en_2 = 1; reg_addr_2 = a2;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_write_en = 1; wb_write_addr = a; wb_write_data = d;
  endtask

  initial begin
    rst_n = 0;
    idle();
    rd(5'd5, 5'd0);
    wb(5'd7, 32'h77);
    #2;
    check("rst_rd1", read_data_1, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    #10 rst_n = 1;
    idle();
    step();

    // Reads of $5 and $0 after reset.
    rd(5'd5, 5'd0); #2;
    check("post_rst_rd1", read_data_1, 32'd0);
    check("post_rst_rd2", read_data_2, 32'd0);
    check("post_rst_stall", {31'd0, stall_req}, 32'd0);
    step();

    // WB write-through then array read.
    idle(); rd(5'd8, 5'd8); wb(5'd8, 32'hDEADBEEF); #2;
    check("wb_through", read_data_1, 32'hDEADBEEF);
    step();
    idle(); rd(5'd8, 5'd1); #2;
    check("wb_array", read_data_1, 32'hDEADBEEF);
    check("unwritten", read_data_2, 32'd0);
    step();

    // Forwarding priority on $3.
    idle(); wb(5'd3, 32'h11); step();
    idle(); rd(5'd3, 5'd3);
    mem_write_en = 1; mem_write_addr = 5'd3; mem_write_data = 32'h22;
    ex_write_en = 1; ex_write_addr = 5'd3; ex_write_data = 32'h33; #2;
    check("prio_ex", read_data_1, 32'h33);
    check("prio_ex_p2", read_data_2, 32'h33);
    step();
    ex_write_en = 0; #2;
    check("prio_mem", read_data_1, 32'h22);
    step();
    mem_write_en = 0; #2;
    check("prio_arr", read_data_2, 32'h11);
    step();

    // Load-use stall detection.
    idle(); ex_write_en = 1; ex_is_load = 1; ex_write_addr = 5'd4;
    reg_read_en_2 = 1; reg_addr_2 = 5'd4; #2;
    check("stall_p2", {31'd0, stall_req}, 32'd1);
    step();
    reg_read_en_2 = 0; #2;
    check("stall_dis", {31'd0, stall_req}, 32'd0);
    step();
    reg_read_en_1 = 1; reg_addr_1 = 5'd4; #2;
    check("stall_p1", {31'd0, stall_req}, 32'd1);
    step();
    ex_write_addr = 5'd0; rd(5'd0, 5'd0); #2;
    check("stall_r0", {31'd0, stall_req}, 32'd0);
    step();
    // Load on $3 shadows MEM bypass; only stall is defined.
    ex_write_addr = 5'd3; rd(5'd3, 5'd8);
    mem_write_en = 1; mem_write_addr = 5'd3; mem_write_data = 32'h22; #2;
    check("stall_shadow", {31'd0, stall_req}, 32'd1);
    check("other_port", read_data_2, 32'hDEADBEEF);
    step();

    // Writes to $0 never land or bypass.
    idle(); rd(5'd0, 5'd0); wb(5'd0, 32'hFFFFFFFF);
    ex_write_en = 1; ex_write_addr = 5'd0; ex_write_data = 32'h5;
    mem_write_en = 1; mem_write_addr = 5'd0; mem_write_data = 32'h9; #2;
    check("r0_fwd", read_data_1, 32'd0);
    step();
    idle(); rd(5'd0, 5'd3); #2;
    check("r0_arr", read_data_1, 32'd0);
    check("r3_kept", read_data_2, 32'h11);
    step();

    // Short mixed sequence, checked by the per-cycle model.
    for (int i = 0; i < 40; i++) begin
      idle();
      reg_read_en_1 = 1'($urandom_range(0, 1)); reg_addr_1 = 5'($urandom_range(0, 7));
      reg_read_en_2 = 1'($urandom_range(0, 1)); reg_addr_2 = 5'($urandom_range(0, 7));
      ex_write_en = 1'($urandom_range(0, 1)); ex_write_addr = 5'($urandom_range(0, 7));
      ex_write_data = $urandom; ex_is_load = 1'($urandom_range(0, 1));
      mem_write_en = 1'($urandom_range(0, 1)); mem_write_addr = 5'($urandom_range(0, 7));
      mem_write_data = $urandom;
      wb_write_en = 1'($urandom_range(0, 1)); wb_write_addr = 5'($urandom_range(0, 7));
      wb_write_data = $urandom;
      step();
    end

`ifdef REG_FILE_DEBUG_PORT_EN
    idle(); wb(5'd31, 32'h1234); step();
    idle(); dbg_addr = 5'd31; step(); #2;
    check("dbg_31", dbg_data, 32'h1234);
    dbg_addr = 5'd0; step(); #2;
    check("dbg_0", dbg_data, 32'd0);
    dbg_addr = 5'd31; step();
    rst_n = 0; #1;
    check("dbg_rst", dbg_data, 32'd0);
    #6 rst_n = 1;
    step();
`endif

    // Reset during a WB write drops the write and clears the array.
    idle(); rd(5'd8, 5'd9); wb(5'd9, 32'hABCD);
    #2 rst_n = 0; #1;
    check("rst_mid_rd1", read_data_1, 32'd0);
    step();
    rst_n = 1; idle(); rd(5'd8, 5'd9); #2;
    check("rst_clr_8", read_data_1, 32'd0);
    check("rst_drop_9", read_data_2, 32'd0);
    step();
    idle(); step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_file_fwd.md
Name: reg_file_fwd

Overview:
- ID-stage register file, directly downstream of the ID register-address generator.
- Consumes its read enables/addresses and returns operand data for the ID/EX latch.
- Takes the WB write port and EX/MEM forwarding buses.
- Resolves RAW hazards by bypassing and raises a load-use stall request for the pipeline controller.

Parameters:
DATA_WIDTH, 32, register/operand width
ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
reg_read_en_1  in  1  read port 1 enable
reg_addr_1  in  ADDR_WIDTH  read port 1 address (rs)
reg_read_en_2  in  1  read port 2 enable
reg_addr_2  in  ADDR_WIDTH  read port 2 address (rt)
ex_write_en  in  1  EX-stage instruction will write a register
ex_write_addr  in  ADDR_WIDTH  EX destination
ex_write_data  in  DATA_WIDTH  EX ALU result
ex_is_load  in  1  EX instruction is a load (data not yet available)
mem_write_en  in  1  MEM-stage write pending
mem_write_addr  in  ADDR_WIDTH  MEM destination
mem_write_data  in  DATA_WIDTH  MEM result
wb_write_en  in  1  WB write strobe (commits to array)
wb_write_addr  in  ADDR_WIDTH  WB destination
wb_write_data  in  DATA_WIDTH  WB data
read_data_1  out  DATA_WIDTH  operand 1
read_data_2  out  DATA_WIDTH  operand 2
stall_req  out  1  load-use stall request to pipeline control

Behaviour:
- Storage: 2**ADDR_WIDTH x DATA_WIDTH flops. Register 0 reads as 0 and is never written.
- Reset: rst_n low asynchronously clears all registers to 0, and clears the debug output register when that feature is enabled. With rst_n low, read_data_1/2 = 0 and stall_req = 0 regardless of inputs.
- Write: on rising clk, if wb_write_en && wb_write_addr != 0, array[wb_write_addr] <= wb_write_data. One write per cycle.
- Read (combinational, zero latency), per port p:
  - If !reg_read_en_p or addr == 0, data = 0.
  - Else priority: EX match (ex_write_en && ex_write_addr == addr && !ex_is_load) -> ex_write_data; then MEM match -> mem_write_data; then WB match (wb_write_en) -> wb_write_data (same-cycle write-through); else array[addr].
  - An EX match with ex_is_load = 1 does not forward. It also blocks lower-priority MEM/WB forwarding for that port, and the port returns array/WB data only as a don't-care while stalled.
- stall_req = ex_write_en && ex_is_load && ex_write_addr != 0 && ((reg_read_en_1 && reg_addr_1 == ex_write_addr) || (reg_read_en_2 && reg_addr_2 == ex_write_addr)). Combinational; held for as long as the condition persists. The controller inserts the bubble and the next cycle resolves via the MEM path.
- Forwarding ignores destination 0 on all stages: an instruction writing $0 never bypasses.
- Simultaneous: both ports on the same address get identical data. A WB write and a read of the same address in one cycle give the new data. A reset mid-write drops the write.

Optional Feature:
- REG_FILE_DEBUG_PORT_EN defined: adds input dbg_addr (ADDR_WIDTH) and output dbg_data (DATA_WIDTH).
  - dbg_data is registered, 1-cycle latency, and returns the array content (no forwarding); dbg_addr 0 returns 0.
  - Reset value 0. Used by the trace/difftest bench.
- Undefined: the ports do not exist and no extra flops are synthesized.

Test Plan:
- Reset, then read $5 and $0 on both ports, enables high -> read_data_1 = read_data_2 = 0, stall_req = 0.
- WB write $8 = 0xDEADBEEF while reading $8 in the same cycle -> read_data_1 = 0xDEADBEEF that cycle. Next cycle, with no WB, still 0xDEADBEEF from the array.
- Array $3 = 0x11, MEM $3 = 0x22, EX $3 = 0x33 (non-load), read $3 -> 0x33. Drop EX -> 0x22. Drop MEM -> 0x11.
- EX load to $4 with port 2 reading $4, enable high -> stall_req = 1. Same with reg_read_en_2 = 0 -> stall_req = 0. EX load to $0 -> stall_req = 0.
- WB write $0 = 0xFFFFFFFF and EX write $0 = 0x5, then read $0 -> 0. The array never changes.
- REG_FILE_DEBUG_PORT_EN: write $31 = 0x1234, set dbg_addr = 31 -> dbg_data = 0x1234 one cycle later. Assert rst_n low mid-sequence -> dbg_data = 0 immediately.
